// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants whole accesses to port A (CPU) or port B (loader/DMA),
// drives the single memory port and returns a one-cycle ack with registered read data.
module mem_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int MEM_LATENCY    = 1,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_a_req,
   input  logic                  i_a_we,
   input  logic [ADDR_WIDTH-1:0] i_a_addr,
   input  logic [DATA_WIDTH-1:0] i_a_wdata,
   output logic                  o_a_ack,
   output logic [DATA_WIDTH-1:0] o_a_rdata,
   input  logic                  i_b_req,
   input  logic                  i_b_we,
   input  logic [ADDR_WIDTH-1:0] i_b_addr,
   input  logic [DATA_WIDTH-1:0] i_b_wdata,
   output logic                  o_b_ack,
   output logic [DATA_WIDTH-1:0] o_b_rdata,
   output logic [1:0]            o_mem_op,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_busy,
   output logic                  o_grant_b
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [1:0] OP_IDLE  = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [3:0] LAT_CNT  = 4'(MEM_LATENCY);

   state_e                r_state;
   state_e                w_stateNext;

   logic                  r_we;
   logic                  r_grantB;
   logic                  r_lastGrantB;
   logic [3:0]            r_cnt;
   logic [1:0]            r_memOp;
   logic [ADDR_WIDTH-1:0] r_memAddr;
   logic [DATA_WIDTH-1:0] r_memWdata;
   logic                  r_aAck;
   logic                  r_bAck;
   logic [DATA_WIDTH-1:0] r_aRdata;
   logic [DATA_WIDTH-1:0] r_bRdata;
   logic                  r_busy;

   logic                  w_anyReq;
   logic                  w_grantB;
   logic                  w_winnerWe;
   logic                  w_latDone;
   logic                  w_load;
   logic                  w_capture;
   logic [1:0]            w_memOpNext;
   logic                  w_aAckNext;
   logic                  w_bAckNext;
   logic                  w_busyNext;

   assign w_anyReq   = i_a_req | i_b_req;
   assign w_winnerWe = w_grantB ? i_b_we : i_a_we;
   assign w_latDone  = (r_cnt == LAT_CNT);

   // On a tie, round-robin hands the grant to whichever port did not own the last access
   always_comb begin
      w_grantB = 1'b0;
      if (i_b_req && !i_a_req) begin
         w_grantB = 1'b1;
      end else if (i_a_req && i_b_req) begin
         w_grantB = (FIXED_PRIORITY != 0) ? 1'b0 : !r_lastGrantB;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
               w_stateNext = ISSUE;
            end
         end
         ISSUE: begin
            w_stateNext = WAIT;
         end
         WAIT: begin
            if (w_latDone) begin
               w_stateNext = RESP;
            end
         end
         RESP: begin
            w_stateNext = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Outputs are registered, so these are the values they take in the next state
   always_comb begin
      w_memOpNext = OP_IDLE;
      w_aAckNext  = 1'b0;
      w_bAckNext  = 1'b0;
      w_load      = 1'b0;
      w_capture   = 1'b0;
      w_busyNext  = (w_stateNext != IDLE);
      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
               w_load      = 1'b1;
               w_memOpNext = w_winnerWe ? OP_WRITE : OP_READ;
            end
         end
         WAIT: begin
            if (w_latDone) begin
               w_capture  = !r_we;
               w_aAckNext = !r_grantB;
               w_bAckNext = r_grantB;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_we         <= 1'b0;
         r_grantB     <= 1'b0;
         r_lastGrantB <= 1'b1;
         r_cnt        <= 4'd0;
         r_memOp      <= OP_IDLE;
         r_memAddr    <= '0;
         r_memWdata   <= '0;
         r_aAck       <= 1'b0;
         r_bAck       <= 1'b0;
         r_aRdata     <= '0;
         r_bRdata     <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_memOp <= w_memOpNext;
         r_aAck  <= w_aAckNext;
         r_bAck  <= w_bAckNext;
         r_busy  <= w_busyNext;

         if (w_load) begin
            r_we         <= w_winnerWe;
            r_grantB     <= w_grantB;
            r_lastGrantB <= w_grantB;
            r_memAddr    <= w_grantB ? i_b_addr  : i_a_addr;
            r_memWdata   <= w_grantB ? i_b_wdata : i_a_wdata;
         end

         if (r_state == ISSUE) begin
            r_cnt <= 4'd1;
         end else if (r_state == WAIT && !w_latDone) begin
            r_cnt <= r_cnt + 4'd1;
         end

         if (w_capture) begin
            if (r_grantB) begin
               r_bRdata <= i_mem_rdata;
            end else begin
               r_aRdata <= i_mem_rdata;
            end
         end
      end
   end

   assign o_a_ack     = r_aAck;
   assign o_b_ack     = r_bAck;
   assign o_a_rdata   = r_aRdata;
   assign o_b_rdata   = r_bRdata;
   assign o_mem_op    = r_memOp;
   assign o_mem_addr  = r_memAddr;
   assign o_mem_wdata = r_memWdata;
   assign o_busy      = r_busy;
   assign o_grant_b   = r_grantB;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances cover latency 1 round-robin,
// latency 1 fixed priority and latency 3 round-robin, each with a small memory model.
module tb_mem_arbiter;

   logic clk;
   logic rst;

   logic        aReq   [3];
   logic        aWe    [3];
   logic [31:0] aAddr  [3];
   logic [31:0] aWdata [3];
   logic        aAck   [3];
   logic [31:0] aRdata [3];
   logic        bReq   [3];
   logic        bWe    [3];
   logic [31:0] bAddr  [3];
   logic [31:0] bWdata [3];
   logic        bAck   [3];
   logic [31:0] bRdata [3];
   logic [1:0]  memOp  [3];
   logic [31:0] memAddr  [3];
   logic [31:0] memWdata [3];
   logic [31:0] memRdata [3];
   logic        busy   [3];
   logic        grantB [3];

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      int          opCycle;
      int          opCount;
      logic [31:0] op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ackCycle;
      int          ackCount;
      int          otherAcks;
      logic [31:0] rdata;
   } obs_t;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return (a == 32'h0040_0000) ? 32'h3C01_1001 : ~a;
   endfunction

   // Each instance gets a memory that returns valid data only exactly LATV cycles after mem_op
   for (genvar g = 0; g < 3; g++) begin : gInst
      localparam int LATV = (g == 2) ? 3 : 1;
      int          k;
      logic [31:0] lAddr;

      mem_arbiter #(
         .DATA_WIDTH     (32),
         .ADDR_WIDTH     (32),
         .MEM_LATENCY    (LATV),
         .FIXED_PRIORITY ((g == 1) ? 1 : 0)
      ) dut (
         .clk         (clk),
         .rst         (rst),
         .i_a_req     (aReq[g]),
         .i_a_we      (aWe[g]),
         .i_a_addr    (aAddr[g]),
         .i_a_wdata   (aWdata[g]),
         .o_a_ack     (aAck[g]),
         .o_a_rdata   (aRdata[g]),
         .i_b_req     (bReq[g]),
         .i_b_we      (bWe[g]),
         .i_b_addr    (bAddr[g]),
         .i_b_wdata   (bWdata[g]),
         .o_b_ack     (bAck[g]),
         .o_b_rdata   (bRdata[g]),
         .o_mem_op    (memOp[g]),
         .o_mem_addr  (memAddr[g]),
         .o_mem_wdata (memWdata[g]),
         .i_mem_rdata (memRdata[g]),
         .o_busy      (busy[g]),
         .o_grant_b   (grantB[g])
      );

      always @(posedge clk) begin
         if (rst) begin
            k <= 0;
         end else if (memOp[g] != 2'd0) begin
            k     <= 1;
            lAddr <= memAddr[g];
         end else if (k != 0 && k < 40) begin
            k <= k + 1;
         end
      end

      assign memRdata[g] = (k == LATV) ? memData(lAddr) : (32'hBAD0_0000 | {16'h0, k[15:0]});
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One access on one port; observes 14 cycles so late or duplicate acks are visible
   task automatic applyStimulus(input int idx, input logic isB, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic changeAddr, output obs_t o);
      logic ownAck;
      logic otherAck;
      o = '{default: 0};
      if (isB) begin
         bReq[idx] = 1'b1; bWe[idx] = we; bAddr[idx] = addr; bWdata[idx] = wdata;
      end else begin
         aReq[idx] = 1'b1; aWe[idx] = we; aAddr[idx] = addr; aWdata[idx] = wdata;
      end
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         ownAck   = isB ? bAck[idx] : aAck[idx];
         otherAck = isB ? aAck[idx] : bAck[idx];
         if (memOp[idx] != 2'd0) begin
            o.opCount++;
            if (o.opCycle == 0) begin
               o.opCycle = n;
               o.op      = 32'(memOp[idx]);
               o.addr    = memAddr[idx];
               o.wdata   = memWdata[idx];
            end
         end
         if (otherAck) o.otherAcks++;
         if (ownAck) begin
            o.ackCount++;
            if (o.ackCycle == 0) begin
               o.ackCycle = n;
               o.rdata    = isB ? bRdata[idx] : aRdata[idx];
            end
            if (isB) bReq[idx] = 1'b0;
            else     aReq[idx] = 1'b0;
         end
         if (changeAddr && n == 2) begin
            if (isB) bAddr[idx] = 32'h4;
            else     aAddr[idx] = 32'h4;
         end
      end
      aReq[idx] = 1'b0;
      bReq[idx] = 1'b0;
   endtask

   // Both ports request continuously; order bit i is 1 when the i-th ack went to B
   task automatic applyTie(input int idx, input int nAcc, output logic [31:0] order,
                           output int lastCycle, output int bothHigh, output int bAcks);
      int acks;
      acks = 0; order = 32'h0; lastCycle = 0; bothHigh = 0; bAcks = 0;
      aReq[idx] = 1'b1; aWe[idx] = 1'b0; aAddr[idx] = 32'h100;
      bReq[idx] = 1'b1; bWe[idx] = 1'b0; bAddr[idx] = 32'h200;
      for (int n = 1; n <= 80 && acks < nAcc; n++) begin
         @(negedge clk);
         if (aAck[idx] && bAck[idx]) bothHigh++;
         if (aAck[idx] || bAck[idx]) begin
            if (bAck[idx]) begin
               order[acks] = 1'b1;
               bAcks++;
            end
            acks++;
            lastCycle = n;
         end
      end
      aReq[idx] = 1'b0;
      bReq[idx] = 1'b0;
   endtask

   initial begin
      obs_t        o;
      logic [31:0] order;
      int          lastCycle;
      int          bothHigh;
      int          bAcks;
      int          ackSeen;

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         aReq[i] = 1'b0; aWe[i] = 1'b0; aAddr[i] = 32'h0; aWdata[i] = 32'h0;
         bReq[i] = 1'b0; bWe[i] = 1'b0; bAddr[i] = 32'h0; bWdata[i] = 32'h0;
      end
      applyReset();

      checkOutput("rst_mem_op",  32'(memOp[0]),  32'd0);
      checkOutput("rst_addr",    memAddr[0],     32'h0);
      checkOutput("rst_wdata",   memWdata[0],    32'h0);
      checkOutput("rst_busy",    32'(busy[0]),   32'd0);
      checkOutput("rst_grant_b", 32'(grantB[0]), 32'd0);
      checkOutput("rst_acks",    32'({aAck[0], bAck[0]}), 32'd0);
      checkOutput("rst_rdata",   aRdata[0] | bRdata[0], 32'h0);

      applyStimulus(0, 1'b0, 1'b0, 32'h0040_0000, 32'h0, 1'b0, o);
      checkOutput("t1_op_cycle",  32'(o.opCycle),  32'd1);
      checkOutput("t1_op",        o.op,            32'd1);
      checkOutput("t1_op_addr",   o.addr,          32'h0040_0000);
      checkOutput("t1_ack_cycle", 32'(o.ackCycle), 32'd3);
      checkOutput("t1_rdata",     o.rdata,         32'h3C01_1001);
      checkOutput("t1_ack_count", 32'(o.ackCount), 32'd1);
      checkOutput("t1_b_ack",     32'(o.otherAcks), 32'd0);

      applyStimulus(0, 1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 1'b0, o);
      checkOutput("t2_op",        o.op,            32'd2);
      checkOutput("t2_op_count",  32'(o.opCount),  32'd1);
      checkOutput("t2_addr",      o.addr,          32'h1001_0000);
      checkOutput("t2_wdata",     o.wdata,         32'hDEAD_BEEF);
      checkOutput("t2_ack_cycle", 32'(o.ackCycle), 32'd3);
      checkOutput("t2_ack_count", 32'(o.ackCount), 32'd1);
      checkOutput("t2_grant_b",   32'(grantB[0]),  32'd1);
      checkOutput("t2_b_rdata",   bRdata[0],       32'h0);
      checkOutput("t2_a_rdata",   aRdata[0],       32'h3C01_1001);

      applyReset();
      applyTie(0, 4, order, lastCycle, bothHigh, bAcks);
      checkOutput("t3_rr_order", order,            32'hA);
      checkOutput("t3_rr_last",  32'(lastCycle),   32'd15);
      checkOutput("t3_rr_both",  32'(bothHigh),    32'd0);
      applyTie(1, 4, order, lastCycle, bothHigh, bAcks);
      checkOutput("t3_fp_order", order,            32'h0);
      checkOutput("t3_fp_last",  32'(lastCycle),   32'd15);
      checkOutput("t3_fp_b_acks", 32'(bAcks),      32'd0);
      repeat (4) @(negedge clk);

      applyStimulus(2, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, o);
      checkOutput("t4_op_cycle",  32'(o.opCycle),  32'd1);
      checkOutput("t4_ack_cycle", 32'(o.ackCycle), 32'd5);
      checkOutput("t4_rdata",     o.rdata,         32'hFFFF_FEFF);
      checkOutput("t4_rdata_hold", aRdata[2],      32'hFFFF_FEFF);

      applyReset();
      bReq[2] = 1'b1; bWe[2] = 1'b0; bAddr[2] = 32'h300;
      @(negedge clk);
      checkOutput("t5_issue", 32'(memOp[2]), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bReq[2] = 1'b0;
      checkOutput("t5_mem_op", 32'(memOp[2]), 32'd0);
      checkOutput("t5_busy",   32'(busy[2]),  32'd0);
      ackSeen = 0;
      for (int n = 0; n < 8; n++) begin
         if (bAck[2]) ackSeen++;
         @(negedge clk);
      end
      checkOutput("t5_no_b_ack", 32'(ackSeen), 32'd0);
      applyTie(2, 1, order, lastCycle, bothHigh, bAcks);
      checkOutput("t5_tie_a",    order,          32'h0);
      checkOutput("t5_tie_last", 32'(lastCycle), 32'd5);
      repeat (6) @(negedge clk);

      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, o);
      checkOutput("t6_op_addr",   o.addr,          32'h0);
      checkOutput("t6_mem_addr",  memAddr[0],      32'h0);
      checkOutput("t6_rdata",     o.rdata,         32'hFFFF_FFFF);
      checkOutput("t6_ack_count", 32'(o.ackCount), 32'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
